mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single RV32I memory block (8 kB RAM plus memory-mapped LED/millis/micros peripherals) between the core's instruction-fetch unit and its load/store unit. Each cycle it grants at most one request and drives the memory's address, data, write-enable and funct3 inputs from the winner. It tracks which requester owns the in-flight read, so the one-cycle-later read data is returned to the correct requester. Throughput is one access per cycle; there are no bubbles between back-to-back grants.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_if.sv | 58 +++++
 rtl/mem_arb_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the fetch / load-store memory
//               arbiter: response-owner encoding and the word-access funct3.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DATA} owner_t;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage
`default_nettype wire

// File: rtl/mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_if
// Description : Bus bundle between the two requesters (instruction fetch,
//               load/store), the arbiter and the shared memory block.
//               slave  : arbiter view (takes requests, drives grants/memory)
//               master : environment view (drives requests and read data)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arb_if;

    // Instruction fetch side
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    // Load/store side
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    // Memory side
    logic [31:0] mem_read_address;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic        mem_write_mem;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_read_data;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_funct3, d_addr, d_wdata,
        input  mem_read_data,
        output if_ready, if_rvalid, if_rdata,
        output d_ready, d_rvalid, d_rdata,
        output mem_read_address, mem_write_address, mem_write_data,
        output mem_write_mem, mem_funct3
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_funct3, d_addr, d_wdata,
        output mem_read_data,
        input  if_ready, if_rvalid, if_rdata,
        input  d_ready, d_rvalid, d_rdata,
        input  mem_read_address, mem_write_address, mem_write_data,
        input  mem_write_mem, mem_funct3
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational two-way picker. A lone request always wins;
//               on a tie prefer_if selects the fetch side. Grants are one-hot
//               or zero.
// Ports       : req_if, req_d   - requests
//               prefer_if       - tie-break select (1 = fetch)
//               gnt_if, gnt_d   - grants
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick (
    input  wire logic req_if,
    input  wire logic req_d,
    input  wire logic prefer_if,
    output logic      gnt_if,
    output logic      gnt_d
);

    assign gnt_if = req_if & (~req_d | prefer_if);
    assign gnt_d  = req_d & ~gnt_if;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one memory block between instruction fetch and the
//               load/store unit. One grant per cycle, read data returned one
//               cycle after the grant to whichever side owns the read.
//               Tie policy: MEM_ARB_ROUND_ROBIN_EN defined -> round robin;
//               undefined -> data wins, with fetch forced through after
//               STARVE_LIMIT consecutive denied cycles.
// Ports       : clk, rst (async, active-high)
//               bus : mem_arb_if.slave (requesters + memory)
// Parameters  : STARVE_LIMIT (1..15) fixed-priority starvation bound
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    mem_arb_if.slave  bus
);

    logic        w_prefer_if;
    logic        w_g_if;
    logic        w_g_d;
    owner_t      r_owner;
    logic [31:0] r_last_raddr;
    logic [31:0] r_last_waddr;
    logic [31:0] r_last_wdata;

    mem_arb_pick u_pick (
        .req_if    (bus.if_req),
        .req_d     (bus.d_req),
        .prefer_if (w_prefer_if),
        .gnt_if    (w_g_if),
        .gnt_d     (w_g_d)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remembers which side won last; reset to data so fetch takes the first tie.
    logic r_last_was_d;

    assign w_prefer_if = r_last_was_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_was_d <= 1'b1;
        end else if (w_g_if) begin
            r_last_was_d <= 1'b0;
        end else if (w_g_d) begin
            r_last_was_d <= 1'b1;
        end
    end
`else
    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    // Counts cycles fetch has been waiting; once it reaches the limit fetch
    // takes the tie. Saturates so a stuck requester cannot wrap it to zero.
    logic [3:0] r_starve_cnt;

    assign w_prefer_if = (r_starve_cnt >= c_starve_limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (w_g_if) begin
            r_starve_cnt <= 4'd0;
        end else if (bus.if_req && (r_starve_cnt != 4'hF)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`endif

    assign bus.if_ready = w_g_if;
    assign bus.d_ready  = w_g_d;

    // Memory-side mux. With no grant the addresses park on their last value
    // so the memory inputs do not toggle needlessly.
    always_comb begin
        bus.mem_read_address  = r_last_raddr;
        bus.mem_write_address = r_last_waddr;
        bus.mem_write_data    = r_last_wdata;
        bus.mem_write_mem     = 1'b0;
        bus.mem_funct3        = FUNCT3_WORD;
        if (w_g_if) begin
            bus.mem_read_address = bus.if_addr;
        end else if (w_g_d) begin
            // Stores also present d_addr on the read port so the read is harmless.
            bus.mem_read_address = bus.d_addr;
            bus.mem_funct3       = bus.d_funct3;
            if (bus.d_we) begin
                bus.mem_write_address = bus.d_addr;
                bus.mem_write_data    = bus.d_wdata;
                bus.mem_write_mem     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_raddr <= 32'd0;
            r_last_waddr <= 32'd0;
            r_last_wdata <= 32'd0;
        end else if (w_g_if) begin
            r_last_raddr <= bus.if_addr;
        end else if (w_g_d) begin
            r_last_raddr <= bus.d_addr;
            if (bus.d_we) begin
                r_last_waddr <= bus.d_addr;
                r_last_wdata <= bus.d_wdata;
            end
        end
    end

    // Owner of the read that the memory returns next cycle; stores own nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else if (w_g_if) begin
            r_owner <= OWN_IF;
        end else if (w_g_d && !bus.d_we) begin
            r_owner <= OWN_DATA;
        end else begin
            r_owner <= OWN_NONE;
        end
    end

    assign bus.if_rvalid = (r_owner == OWN_IF);
    assign bus.d_rvalid  = (r_owner == OWN_DATA);
    assign bus.if_rdata  = bus.mem_read_data;
    assign bus.d_rdata   = bus.mem_read_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Contains a small memory
//               (word store, synchronous read, funct3 extension), a byte-level
//               reference model of arbitration and memory contents, directed
//               scenarios and a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int STARVE = 2;

    logic clk;
    logic rst;

    mem_arb_if bus ();

    mem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- environment memory (word organised) ----------------
    logic [31:0] env_mem [logic [29:0]];

    function automatic logic [31:0] env_word(input logic [31:0] a);
        if (env_mem.exists(a[31:2])) return env_mem[a[31:2]];
        return 32'd0;
    endfunction

    function automatic logic [31:0] env_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = env_word(a);
        b = w[8*a[1:0] +: 8];
        h = w[16*a[1] +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [31:0] w;
        bus.mem_read_data <= env_load(bus.mem_read_address, bus.mem_funct3);
        if (bus.mem_write_mem) begin
            w = env_word(bus.mem_write_address);
            case (bus.mem_funct3)
                3'b000:  w[8*bus.mem_write_address[1:0] +: 8] = bus.mem_write_data[7:0];
                3'b001:  w[16*bus.mem_write_address[1] +: 16] = bus.mem_write_data[15:0];
                default: w = bus.mem_write_data;
            endcase
            env_mem[bus.mem_write_address[31:2]] = w;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  mb [logic [31:0]];
    int          exp_owner;       // 0 none, 1 fetch, 2 data
    logic [31:0] exp_rdata;
    int          m_starve;
    bit          m_last_d;
    logic [31:0] m_raddr, m_waddr, m_wdata;
    bit          last_gi, last_gd;

    int n_pass, n_tot;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic logic [7:0] rb(input logic [31:0] a);
        if (mb.exists(a)) return mb[a];
        return 8'd0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f3);
        logic [15:0] h;
        h = {rb(a + 1), rb(a)};
        case (f3)
            3'b000:  return {{24{rb(a)[7]}}, rb(a)};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, rb(a)};
            3'b101:  return {16'd0, h};
            default: return {rb(a + 3), rb(a + 2), h};
        endcase
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        int n;
        n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        for (int i = 0; i < n; i++) mb[a + i] = d[8*i +: 8];
    endtask

    task automatic model_reset();
        exp_owner = 0;
        m_starve  = 0;
        m_last_d  = 1'b1;
        m_raddr   = 32'd0;
        m_waddr   = 32'd0;
        m_wdata   = 32'd0;
    endtask

    // Checks everything visible this cycle, then advances the model across
    // the coming edge. Called at the negedge; returns just after the posedge.
    task automatic cycle();
        bit gi, gd, pref;
        @(negedge clk);
        if (rst) begin
            model_reset();
            last_gi = 1'b0;
            last_gd = 1'b0;
        end else begin
            chk("if_rvalid", {31'd0, bus.if_rvalid}, {31'd0, exp_owner == 1});
            chk("d_rvalid", {31'd0, bus.d_rvalid}, {31'd0, exp_owner == 2});
            if (exp_owner == 1) chk("if_rdata", bus.if_rdata, exp_rdata);
            if (exp_owner == 2) chk("d_rdata", bus.d_rdata, exp_rdata);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pref = m_last_d;
`else
            pref = (m_starve >= STARVE);
`endif
            gi = bus.if_req && (!bus.d_req || pref);
            gd = bus.d_req && !gi;
            chk("if_ready", {31'd0, bus.if_ready}, {31'd0, gi});
            chk("d_ready", {31'd0, bus.d_ready}, {31'd0, gd});
            chk("mem_write_mem", {31'd0, bus.mem_write_mem}, {31'd0, gd && bus.d_we});
            if (gi) begin
                chk("raddr_if", bus.mem_read_address, bus.if_addr);
                chk("funct3_if", {29'd0, bus.mem_funct3}, 32'd2);
            end else if (gd) begin
                chk("raddr_d", bus.mem_read_address, bus.d_addr);
                chk("funct3_d", {29'd0, bus.mem_funct3}, {29'd0, bus.d_funct3});
                if (bus.d_we) begin
                    chk("waddr", bus.mem_write_address, bus.d_addr);
                    chk("wdata", bus.mem_write_data, bus.d_wdata);
                end
            end else begin
                chk("raddr_hold", bus.mem_read_address, m_raddr);
                chk("waddr_hold", bus.mem_write_address, m_waddr);
                chk("wdata_hold", bus.mem_write_data, m_wdata);
                chk("funct3_idle", {29'd0, bus.mem_funct3}, 32'd2);
            end
            // advance
            exp_owner = 0;
            if (gi) begin
                exp_owner = 1;
                exp_rdata = m_load(bus.if_addr, 3'b010);
                m_raddr   = bus.if_addr;
            end else if (gd) begin
                m_raddr = bus.d_addr;
                if (bus.d_we) begin
                    m_store(bus.d_addr, bus.d_funct3, bus.d_wdata);
                    m_waddr = bus.d_addr;
                    m_wdata = bus.d_wdata;
                end else begin
                    exp_owner = 2;
                    exp_rdata = m_load(bus.d_addr, bus.d_funct3);
                end
            end
            if (gi) m_starve = 0;
            else if (bus.if_req) m_starve++;
            if (gi) m_last_d = 1'b0;
            else if (gd) m_last_d = 1'b1;
            last_gi = gi;
            last_gd = gd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input bit req, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.d_req    = req;
        bus.d_we     = we;
        bus.d_funct3 = f3;
        bus.d_addr   = a;
        bus.d_wdata  = wd;
    endtask

    function automatic logic [31:0] rand_base();
        int idx;
        idx = $urandom_range(0, 8);
        return (idx == 8) ? 32'hFFFF_FFFC : 32'h100 + 32'(4 * idx);
    endfunction

    initial begin
        string seq;
        bit    if_pend, d_pend;
        logic [2:0] f3;
        logic [31:0] a;
        n_pass = 0;
        n_tot  = 0;
        last_gi = 1'b0;
        last_gd = 1'b0;
        rst = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = 32'd0;
        set_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        env_mem[30'h4] = 32'h0050_0093;
        m_store(32'h10, 3'b010, 32'h0050_0093);
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("rst_if_rvalid", {31'd0, bus.if_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
        chk("rst_write_mem", {31'd0, bus.mem_write_mem}, 32'd0);
        cycle();

        // fetch alone
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        cycle();
        chk("fetch_ready", {31'd0, last_gi}, 32'd1);
        bus.if_req = 1'b0;
        chk("fetch_rvalid", {31'd0, bus.if_rvalid}, 32'd1);
        chk("fetch_rdata", bus.if_rdata, 32'h0050_0093);
        chk("fetch_no_d_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
        cycle();

        // store then lbu
        set_d(1'b1, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
        cycle();
        chk("store_ready", {31'd0, last_gd}, 32'd1);
        chk("store_no_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
        set_d(1'b1, 1'b0, 3'b100, 32'h101, 32'd0);
        cycle();
        set_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        chk("lbu_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
        chk("lbu_rdata", bus.d_rdata, 32'h0000_00BE);
        cycle();

        // peripheral word
        set_d(1'b1, 1'b1, 3'b010, 32'hFFFF_FFFC, 32'h1122_3344);
        cycle();
        set_d(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'd0);
        cycle();
        chk("periph_rdata", bus.d_rdata, 32'h1122_3344);

        // simultaneous requests held high
`ifdef MEM_ARB_ROUND_ROBIN_EN
        seq = "IDIDID";
`else
        seq = "DDIDDI";
`endif
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        set_d(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("tie_grant_if", {31'd0, last_gi}, {31'd0, seq[i] == "I"});
        end
        bus.if_req = 1'b0;
        set_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        cycle();
        cycle();

        // reset in the cycle after a fetch grant
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        cycle();
        bus.if_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_if_rvalid", {31'd0, bus.if_rvalid}, 32'd0);
        model_reset();
        cycle();
        rst = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h104;
        set_d(1'b1, 1'b0, 3'b010, 32'h108, 32'd0);
        cycle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("post_rst_tie_if", {31'd0, last_gi}, 32'd1);
`else
        chk("post_rst_tie_if", {31'd0, last_gi}, 32'd0);
`endif
        bus.if_req = 1'b0;
        set_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        cycle();

        // randomized traffic
        if_pend = 1'b0;
        d_pend  = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (last_gi) if_pend = 1'b0;
            if (last_gd) d_pend = 1'b0;
            if (!if_pend && $urandom_range(0, 3) != 0) begin
                if_pend = 1'b1;
                bus.if_addr = ($urandom_range(0, 4) == 0) ? 32'h10 : rand_base();
            end
            bus.if_req = if_pend;
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1'b1;
                a = rand_base();
                if ($urandom_range(0, 1) == 1) begin
                    f3 = 3'($urandom_range(0, 2));
                    bus.d_we = 1'b1;
                end else begin
                    case ($urandom_range(0, 4))
                        0: f3 = 3'b000;
                        1: f3 = 3'b001;
                        2: f3 = 3'b010;
                        3: f3 = 3'b100;
                        default: f3 = 3'b101;
                    endcase
                    bus.d_we = 1'b0;
                end
                if (f3[1:0] == 2'b00) a = a + 32'($urandom_range(0, 3));
                else if (f3[1:0] == 2'b01) a = a + 32'(2 * $urandom_range(0, 1));
                bus.d_funct3 = f3;
                bus.d_addr   = a;
                bus.d_wdata  = $urandom;
            end
            bus.d_req = d_pend;
            cycle();
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
